// File: rtl/stick_acq_framer.sv
// Multi-channel ADC burst framer: sync-triggered, decimated capture,
// two samples per word, framed stream out through a local FWFT FIFO.
module stick_acq_framer #(
    parameter int CH_NUM  = 4,
    parameter int DW      = 12,
    parameter int LEN_W   = 10,
    parameter int FIFO_AW = 5
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   i_sync,
    input  logic                   i_en,
    input  logic [CH_NUM*DW-1:0]   i_data,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [7:0]             i_decim,
    output logic [31:0]            o_tx_data,
    output logic                   o_tx_vld,
    output logic                   o_tx_sop,
    output logic                   o_tx_eop,
    input  logic                   i_tx_rdy,
    output logic                   o_busy,
    output logic                   o_ovf,
    output logic [15:0]            o_frame_cnt
);

    localparam int HALF  = CH_NUM / 2;
    localparam int WI_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, ACQ, PACK, EOPW} state_t;

    logic [1:0]           sync_q;
    logic                 sync_prev_q;
    logic                 start_q;

    state_t               state_q;
    logic [CH_NUM*DW-1:0] samp_q;
    logic [WI_W-1:0]      widx_q;
    logic [LEN_W-1:0]     rem_q;
    logic [7:0]           decim_q;
    logic [7:0]           tcnt_q;
    logic [15:0]          frame_cnt_q;
    logic                 ovf_q;
    logic                 busy_q;

    logic [33:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q;
    logic [FIFO_AW-1:0]   rd_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [31:0]          data_q;
    logic                 vld_q;
    logic                 sop_q;
    logic                 eop_q;

    logic                 pop;
    logic                 fifo_ok;
    logic                 last_w;
    logic                 eop_w;
    logic                 start_ok;
    logic                 wr_en;
    logic [33:0]          wr_word;
    logic [31:0]          pack_word;
    int                   pidx;
    logic [FIFO_AW-1:0]   head_d;
    logic                 avail_d;

    // Sample period minus one, never shorter than one pack burst
    function automatic logic [7:0] per_m1(input logic [7:0] d);
        return (d >= 8'(HALF - 1)) ? d : 8'(HALF - 1);
    endfunction

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], i_sync};
            sync_prev_q <= sync_q[1];
            start_q     <= sync_q[1] & ~sync_prev_q;
        end
    end

    assign pop      = vld_q & i_tx_rdy;
    assign fifo_ok  = (cnt_q != CW'(DEPTH)) | pop;
    assign last_w   = (widx_q == WI_W'(HALF - 1));
    assign eop_w    = last_w & (rem_q == '0);
    assign start_ok = start_q & i_en & (i_len != '0);

    always_comb begin
        pack_word = '0;
        pidx      = int'(widx_q) * 2 * DW;
        pack_word[DW-1:0]   = samp_q[pidx +: DW];
        pack_word[16 +: DW] = samp_q[pidx + DW +: DW];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_word = '0;
        unique case (state_q)
            IDLE: begin
                if (start_ok && fifo_ok) begin
                    wr_en   = 1'b1;
                    wr_word = {2'b10, 16'hA55A, frame_cnt_q};
                end
            end
            PACK: begin
                wr_en   = fifo_ok;
                wr_word = {1'b0, eop_w, pack_word};
            end
            EOPW: begin
                wr_en   = fifo_ok;
                wr_word = {2'b01, pack_word};
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            samp_q      <= '0;
            widx_q      <= '0;
            rem_q       <= '0;
            decim_q     <= '0;
            tcnt_q      <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (tcnt_q != '0) tcnt_q <= tcnt_q - 8'd1;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (fifo_ok) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            ovf_q       <= 1'b0;
                            rem_q       <= i_len - LEN_W'(1);
                            decim_q     <= i_decim;
                            samp_q      <= i_data;
                            widx_q      <= '0;
                            tcnt_q      <= per_m1(i_decim);
                            state_q     <= PACK;
                            busy_q      <= 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                ACQ: begin
                    if (tcnt_q == '0) begin
                        samp_q  <= i_data;
                        rem_q   <= rem_q - LEN_W'(1);
                        widx_q  <= '0;
                        tcnt_q  <= per_m1(decim_q);
                        state_q <= PACK;
                    end
                end
                PACK: begin
                    if (!fifo_ok && !eop_w) ovf_q <= 1'b1;
                    if (!last_w) begin
                        widx_q <= widx_q + WI_W'(1);
                    end else if (eop_w) begin
                        if (fifo_ok) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= EOPW;
                        end
                    end else if (tcnt_q == '0) begin
                        // Tick lands on the last pack cycle: latch back-to-back
                        samp_q <= i_data;
                        rem_q  <= rem_q - LEN_W'(1);
                        widx_q <= '0;
                        tcnt_q <= per_m1(decim_q);
                    end else begin
                        state_q <= ACQ;
                    end
                end
                EOPW: begin
                    if (fifo_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_word;
    end

    // Output register preloads the entry that will be head after this edge
    assign head_d  = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    assign avail_d = pop ? (cnt_q > CW'(1)) : (cnt_q != '0);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
            vld_q <= avail_d;
            if (avail_d) {sop_q, eop_q, data_q} <= mem[head_d];
        end
    end

    assign o_tx_data   = data_q;
    assign o_tx_vld    = vld_q;
    assign o_tx_sop    = sop_q;
    assign o_tx_eop    = eop_q;
    assign o_busy      = busy_q;
    assign o_ovf       = ovf_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule
